// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO arbiter.
package fifo_arb_pkg;

    // Arbiter FSM: IDLE between grants, SERVE while a queue holds the grant.
    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_e;

    // Index width for n items, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/m_FIFO.sv
// Memory FIFO with combinational head read and an occupancy counter.
// Write and read may coincide, including when the FIFO is full.
module m_FIFO
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wd,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              last
);

    localparam int unsigned AW = idx_w(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_wr;
    logic              do_rd;

    // Pointers never move on a pop from empty or a push to full without a pop.
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign last    = (count_q == CW'(1));
    assign rd_data = mem[rd_ptr_q];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wd;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count_q <= count_q + CW'(1);
            end else if (do_rd && !do_wr) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// NQ input queues drained onto one ready/valid output by a round-robin
// arbiter that grants up to BURST pops per grant, with one idle cycle
// between grants.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NQ     = 4,
    parameter int unsigned BURST  = 2,
    localparam int unsigned QW    = idx_w(NQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NQ-1:0]        in_wren,
    input  logic [NQ*DWIDTH-1:0] in_wd,
    output logic [NQ-1:0]        in_full,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DWIDTH-1:0]    out_data,
    output logic [QW-1:0]        out_qid,
    output logic [NQ-1:0]        ovf
);

    localparam int unsigned BW = idx_w(BURST);

    logic [NQ-1:0]     q_full;
    logic [NQ-1:0]     q_empty;
    logic [NQ-1:0]     q_last;
    logic [NQ-1:0]     q_wr;
    logic [NQ-1:0]     q_rd;
    logic [DWIDTH-1:0] q_head [NQ];

    arb_state_e        state_q;
    logic [QW-1:0]     grant_q;
    logic [QW-1:0]     rr_ptr_q;
    logic [BW-1:0]     burst_cnt_q;
    logic [NQ-1:0]     ovf_q;

    logic              hs;
    logic              release_grant;
    logic              any_ready;
    logic [QW-1:0]     next_grant;

    for (genvar q = 0; q < NQ; q++) begin : g_queue
        m_FIFO #(
            .DWIDTH (DWIDTH),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (q_wr[q]),
            .wd      (in_wd[q*DWIDTH +: DWIDTH]),
            .rd_en   (q_rd[q]),
            .rd_data (q_head[q]),
            .full    (q_full[q]),
            .empty   (q_empty[q]),
            .last    (q_last[q])
        );
    end

    assign out_valid = (state_q == SERVE) & ~q_empty[grant_q];
    assign out_data  = q_head[grant_q];
    assign out_qid   = (state_q == SERVE) ? grant_q : '0;
    assign hs        = out_valid & out_ready;
    assign ovf       = ovf_q;

    // Pop only the granted queue; a popping queue is not reported full so a
    // same-cycle push into it is accepted.
    always_comb begin
        q_rd    = '0;
        in_full = '0;
        q_wr    = '0;
        for (int q = 0; q < NQ; q++) begin
            q_rd[q]    = hs & (grant_q == QW'(q));
            in_full[q] = q_full[q] & ~q_rd[q];
            q_wr[q]    = in_wren[q] & ~in_full[q];
        end
    end

    // First non-empty queue at or above rr_ptr, wrapping modulo NQ.
    always_comb begin
        any_ready  = 1'b0;
        next_grant = rr_ptr_q;
        for (int i = 0; i < NQ; i++) begin
            if (!any_ready && !q_empty[rr_ptr_q + QW'(i)]) begin
                any_ready  = 1'b1;
                next_grant = rr_ptr_q + QW'(i);
            end
        end
    end

    // Release on the burst-ending pop, the pop of the last word, or an empty grant.
    assign release_grant = (state_q == SERVE) &
                           (hs ? ((burst_cnt_q == BW'(BURST - 1)) | q_last[grant_q])
                               : q_empty[grant_q]);

    // Arbiter FSM with grant, round-robin pointer and burst counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_ready) begin
                        state_q     <= SERVE;
                        grant_q     <= next_grant;
                        burst_cnt_q <= '0;
                    end
                end
                SERVE: begin
                    if (hs) begin
                        burst_cnt_q <= burst_cnt_q + BW'(1);
                    end
                    if (release_grant) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= grant_q + QW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky overflow: a push that found its queue full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_q | (in_wren & in_full);
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: a vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_fifo_rr_arbiter;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int NQ    = 4;
    localparam int BURST = 2;
    localparam int QW    = 2;

    logic              clk;
    logic              rst_n;
    logic [NQ-1:0]     in_wren;
    logic [NQ*DW-1:0]  in_wd;
    logic [NQ-1:0]     in_full;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [QW-1:0]     out_qid;
    logic [NQ-1:0]     ovf;

    fifo_rr_arbiter #(
        .DWIDTH (DW),
        .DEPTH  (DEPTH),
        .NQ     (NQ),
        .BURST  (BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_wren   (in_wren),
        .in_wd     (in_wd),
        .in_full   (in_full),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_qid   (out_qid),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [NQ-1:0]    wren;
        logic [NQ*DW-1:0] wd;
        logic             rdy;
        logic             ev;
        logic [DW-1:0]    ed;
        logic [QW-1:0]    eq;
    } vec_t;

    vec_t           tbl [14];
    logic [DW-1:0]  got [$];
    logic [DW-1:0]  exp_words [$];

    // Reference model state: contents per queue and the arbiter's grant.
    logic [DW-1:0]  mq [NQ][$];
    bit             m_serv;
    int             m_grant;
    int             m_rr;
    int             m_cnt;
    logic [NQ-1:0]  m_ovf;

    function automatic logic [NQ*DW-1:0] lane(input int q, input logic [DW-1:0] v);
        logic [NQ*DW-1:0] r;
        r = '0;
        r[q*DW +: DW] = v;
        return r;
    endfunction

    function automatic vec_t mk(input logic [NQ-1:0] w, input logic [NQ*DW-1:0] d,
                                input logic r, input logic ev, input logic [DW-1:0] ed,
                                input logic [QW-1:0] eq);
        vec_t v;
        v.wren = w;
        v.wd   = d;
        v.rdy  = r;
        v.ev   = ev;
        v.ed   = ed;
        v.eq   = eq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; outputs are read 1ns later.
    task automatic apply(input logic [NQ-1:0] w, input logic [NQ*DW-1:0] d, input logic r);
        @(negedge clk);
        in_wren   = w;
        in_wd     = d;
        out_ready = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_wren   = '0;
        in_wd     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pop words with out_ready high, collecting them and their queue ids.
    task automatic drain(input int qsel, input int n, input int budget);
        got.delete();
        for (int i = 0; i < budget && got.size() < n; i++) begin
            apply('0, '0, 1'b1);
            if (out_valid === 1'b1) begin
                chk("drain_qid", 32'(out_qid), 32'(qsel));
                got.push_back(out_data);
            end
        end
        chk("drain_count", 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            chk("drain_word", 32'(got[i]), 32'(exp_words[i]));
        end
    endtask

    task automatic model_reset();
        for (int q = 0; q < NQ; q++) mq[q].delete();
        m_serv  = 1'b0;
        m_grant = 0;
        m_rr    = 0;
        m_cnt   = 0;
        m_ovf   = '0;
    endtask

    task automatic random_phase(input int ncyc);
        logic [NQ-1:0]    w;
        logic [NQ*DW-1:0] d;
        logic             r;
        logic             ev;
        logic             hs;
        logic [NQ-1:0]    ef;
        int               sz [NQ];
        int               pct;
        bit               found;
        bit               rel;
        for (int c = 0; c < ncyc; c++) begin
            pct = ((c / 200) % 2 == 0) ? 80 : 25;
            for (int q = 0; q < NQ; q++) begin
                w[q] = ($urandom_range(0, 99) < 35);
                d[q*DW +: DW] = DW'($urandom_range(0, 255));
            end
            r = ($urandom_range(0, 99) < pct);
            apply(w, d, r);

            ev = m_serv && (mq[m_grant].size() > 0);
            hs = ev && r;
            for (int q = 0; q < NQ; q++) begin
                ef[q] = (mq[q].size() == DEPTH) && !(hs && q == m_grant);
            end
            chk("rnd_valid", 32'(out_valid), 32'(ev));
            chk("rnd_qid", 32'(out_qid), m_serv ? 32'(m_grant) : 32'd0);
            if (ev) chk("rnd_data", 32'(out_data), 32'(mq[m_grant][0]));
            chk("rnd_full", 32'(in_full), 32'(ef));
            chk("rnd_ovf", 32'(ovf), 32'(m_ovf));

            // Advance the model across the coming rising edge.
            for (int q = 0; q < NQ; q++) sz[q] = mq[q].size();
            if (hs) void'(mq[m_grant].pop_front());
            for (int q = 0; q < NQ; q++) begin
                if (w[q]) begin
                    if (ef[q]) m_ovf[q] = 1'b1;
                    else mq[q].push_back(d[q*DW +: DW]);
                end
            end
            if (!m_serv) begin
                found = 1'b0;
                for (int i = 0; i < NQ; i++) begin
                    if (!found && sz[(m_rr + i) % NQ] > 0) begin
                        found   = 1'b1;
                        m_grant = (m_rr + i) % NQ;
                    end
                end
                if (found) begin
                    m_serv = 1'b1;
                    m_cnt  = 0;
                end
            end else begin
                rel = 1'b0;
                if (hs) begin
                    m_cnt++;
                    rel = (m_cnt == BURST) || (sz[m_grant] == 1);
                end else begin
                    rel = (sz[m_grant] == 0);
                end
                if (rel) begin
                    m_serv = 1'b0;
                    m_rr   = (m_grant + 1) % NQ;
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_wren   = '0;
        in_wd     = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_full", 32'(in_full), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_qid", 32'(out_qid), 32'd0);
        rst_n = 1'b1;

        // Single push latency, then q0/q1 ordering with idle gaps between grants.
        tbl[0]  = mk(4'b0100, lane(2, 8'hA5), 1'b1, 1'b0, 8'h00, 2'd0);
        tbl[1]  = mk(4'b0000, '0, 1'b1, 1'b0, 8'h00, 2'd0);
        tbl[2]  = mk(4'b0000, '0, 1'b1, 1'b1, 8'hA5, 2'd2);
        tbl[3]  = mk(4'b0000, '0, 1'b1, 1'b0, 8'h00, 2'd0);
        tbl[4]  = mk(4'b0000, '0, 1'b1, 1'b0, 8'h00, 2'd0);
        tbl[5]  = mk(4'b0011, lane(0, 8'h10) | lane(1, 8'h20), 1'b1, 1'b0, 8'h00, 2'd0);
        tbl[6]  = mk(4'b0001, lane(0, 8'h11), 1'b1, 1'b0, 8'h00, 2'd0);
        tbl[7]  = mk(4'b0001, lane(0, 8'h12), 1'b1, 1'b1, 8'h10, 2'd0);
        tbl[8]  = mk(4'b0000, '0, 1'b1, 1'b1, 8'h11, 2'd0);
        tbl[9]  = mk(4'b0000, '0, 1'b1, 1'b0, 8'h00, 2'd0);
        tbl[10] = mk(4'b0000, '0, 1'b1, 1'b1, 8'h20, 2'd1);
        tbl[11] = mk(4'b0000, '0, 1'b1, 1'b0, 8'h00, 2'd0);
        tbl[12] = mk(4'b0000, '0, 1'b1, 1'b1, 8'h12, 2'd0);
        tbl[13] = mk(4'b0000, '0, 1'b1, 1'b0, 8'h00, 2'd0);
        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].wren, tbl[i].wd, tbl[i].rdy);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_qid", i), 32'(out_qid), 32'(tbl[i].eq));
            if (tbl[i].ev) chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
            chk($sformatf("vec%0d_full", i), 32'(in_full), 32'd0);
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'd0);
        end

        // Overfill q3 with no pops: fifth word dropped and ovf set.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            apply(4'b1000, lane(3, DW'(8'h30 + k)), 1'b0);
            chk($sformatf("ovfl_full_before_push%0d", k), 32'(in_full[3]), (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("ovfl_ovf_before_push%0d", k), 32'(ovf[3]), 32'd0);
        end
        apply('0, '0, 1'b0);
        chk("ovfl_full", 32'(in_full), 32'b1000);
        chk("ovfl_ovf", 32'(ovf), 32'b1000);
        exp_words = '{8'h30, 8'h31, 8'h32, 8'h33};
        drain(3, 4, 20);
        for (int k = 0; k < 3; k++) begin
            apply('0, '0, 1'b1);
            chk("ovfl_no_extra", 32'(out_valid), 32'd0);
        end
        chk("ovfl_sticky", 32'(ovf), 32'b1000);

        // Back-pressure: outputs hold while out_ready is low.
        do_reset();
        apply(4'b0010, lane(1, 8'h51), 1'b0);
        apply(4'b0010, lane(1, 8'h52), 1'b0);
        for (int i = 0; i < 10 && out_valid !== 1'b1; i++) apply('0, '0, 1'b0);
        chk("hold_wait_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            apply('0, '0, 1'b0);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'h51);
            chk("hold_qid", 32'(out_qid), 32'd1);
        end
        exp_words = '{8'h51, 8'h52};
        drain(1, 2, 20);

        // Push into a full queue on the same cycle it pops.
        do_reset();
        for (int k = 0; k < 4; k++) apply(4'b0001, lane(0, DW'(8'h60 + k)), 1'b0);
        apply('0, '0, 1'b0);
        chk("fullpp_full", 32'(in_full[0]), 32'd1);
        chk("fullpp_head", 32'(out_data), 32'h60);
        apply(4'b0001, lane(0, 8'h77), 1'b1);
        chk("fullpp_full_masked", 32'(in_full[0]), 32'd0);
        chk("fullpp_valid", 32'(out_valid), 32'd1);
        exp_words = '{8'h61, 8'h62, 8'h63, 8'h77};
        drain(0, 4, 30);
        chk("fullpp_ovf", 32'(ovf), 32'd0);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        apply(4'b0100, lane(2, 8'hC0), 1'b0);
        apply(4'b1110, lane(1, 8'hB0) | lane(2, 8'hC1) | lane(3, 8'hD0), 1'b0);
        apply(4'b1100, lane(2, 8'hC2) | lane(3, 8'hD1), 1'b0);
        apply(4'b1000, lane(3, 8'hD2), 1'b0);
        apply(4'b1000, lane(3, 8'hD3), 1'b0);
        apply(4'b1000, lane(3, 8'hD4), 1'b0);
        apply('0, '0, 1'b0);
        chk("rst_pre_ovf", 32'(ovf), 32'b1000);
        chk("rst_pre_full", 32'(in_full), 32'b1000);
        chk("rst_pre_qid", 32'(out_qid), 32'd2);
        chk("rst_pre_data", 32'(out_data), 32'hC0);
        apply('0, '0, 1'b1);
        apply('0, '0, 1'b1);
        chk("rst_mid_burst_data", 32'(out_data), 32'hC1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_full", 32'(in_full), 32'd0);
        chk("rst_async_ovf", 32'(ovf), 32'd0);
        chk("rst_async_qid", 32'(out_qid), 32'd0);
        in_wren   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apply(4'b1010, lane(1, 8'h91) | lane(3, 8'h93), 1'b1);
        chk("rst_post_empty", 32'(out_valid), 32'd0);
        apply('0, '0, 1'b1);
        chk("rst_post_idle", 32'(out_valid), 32'd0);
        apply('0, '0, 1'b1);
        chk("rst_post_valid", 32'(out_valid), 32'd1);
        chk("rst_post_qid", 32'(out_qid), 32'd1);
        chk("rst_post_data", 32'(out_data), 32'h91);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        random_phase(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
